// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a fixed read latency.
// Each requester uses a req/ack handshake; every output is registered.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        LAT  = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   lat_cnt_d;
    logic               txn_we;
    logic               txn_we_d;
    logic               last_b;
    logic               last_b_d;
    logic               pick_b;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic               mem_we_d;
    logic               a_ack_d;
    logic               b_ack_d;
    logic [DATA_W-1:0]  a_rdata_d;
    logic [DATA_W-1:0]  b_rdata_d;
    logic               busy_d;
    logic               owner_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state;
        lat_cnt_d   = lat_cnt;
        txn_we_d    = txn_we;
        last_b_d    = last_b;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata;
        b_rdata_d   = b_rdata;
        owner_d     = owner;
        // B wins if it is alone, or if both ask and A was served last
        pick_b      = b_req & (~a_req | ~last_b);

        unique case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_d     = pick_b;
                    txn_we_d    = pick_b ? b_we    : a_we;
                    mem_addr_d  = pick_b ? b_addr  : a_addr;
                    mem_wdata_d = pick_b ? b_wdata : a_wdata;
                    mem_we_d    = pick_b ? b_we    : a_we;
                    state_d     = ACC;
                end
            end
            ACC: begin
                if (txn_we) begin
                    a_ack_d  = ~owner;
                    b_ack_d  = owner;
                    last_b_d = owner;
                    state_d  = ACK;
                end else begin
                    lat_cnt_d = '0;
                    state_d   = LAT;
                end
            end
            LAT: begin
                if (lat_cnt == CNT_LAST) begin
                    if (owner) begin
                        b_rdata_d = mem_rdata;
                    end else begin
                        a_rdata_d = mem_rdata;
                    end
                    a_ack_d  = ~owner;
                    b_ack_d  = owner;
                    last_b_d = owner;
                    state_d  = ACK;
                end else begin
                    lat_cnt_d = lat_cnt + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers; last_b resets to B so A wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt   <= '0;
            txn_we    <= 1'b0;
            last_b    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            lat_cnt   <= lat_cnt_d;
            txn_we    <= txn_we_d;
            last_b    <= last_b_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            a_ack     <= a_ack_d;
            b_ack     <= b_ack_d;
            a_rdata   <= a_rdata_d;
            b_rdata   <= b_rdata_d;
            busy      <= busy_d;
            owner     <= owner_d;
        end
    end

endmodule
